// File: rtl/fault_monitor_pkg.sv
// Shared types and invariant index constants for the fault alarm monitor.
package fault_monitor_pkg;

   typedef enum logic [1:0] {
      PRIV_U = 2'b00,
      PRIV_S = 2'b01,
      PRIV_M = 2'b11
   } priv_lvl_e;

   localparam int unsigned INV_FSM         = 0;
   localparam int unsigned INV_PRIV        = 1;
   localparam int unsigned INV_REGION_BASE = 2;

endpackage

// File: rtl/fault_leaky_counter.sv
// Saturating violation counter that leaks one count per DecayPeriod quiet cycles.
module fault_leaky_counter #(
   parameter int unsigned CntWidth    = 4,
   parameter int unsigned DecayPeriod = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clr_i,
   input  logic                inc_i,
   output logic [CntWidth-1:0] count_o
);

   localparam int unsigned TimerWidth = (DecayPeriod > 1) ? $clog2(DecayPeriod) : 1;
   localparam logic [TimerWidth-1:0] TimerLast =
      TimerWidth'((DecayPeriod > 0) ? DecayPeriod - 1 : 0);

   logic [CntWidth-1:0]   count_q, count_d;
   logic [TimerWidth-1:0] timer_q, timer_d;

   always_comb begin
      count_d = count_q;
      timer_d = timer_q;
      if (clr_i) begin
         // An increment in the clear cycle lands on the cleared value.
         count_d = inc_i ? CntWidth'(1) : '0;
         timer_d = '0;
      end else if (inc_i) begin
         if (!(&count_q)) begin
            count_d = count_q + CntWidth'(1);
         end
         timer_d = '0;
      end else if (DecayPeriod != 0) begin
         if (timer_q == TimerLast) begin
            timer_d = '0;
            if (count_q != '0) begin
               count_d = count_q - CntWidth'(1);
            end
         end else begin
            timer_d = timer_q + TimerWidth'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
         timer_q <= '0;
      end else begin
         count_q <= count_d;
         timer_q <= timer_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/fault_alarm_monitor.sv
// Per-cycle security invariant checker feeding a leaky counter, sticky cause
// flags and a sticky threshold alarm.
module fault_alarm_monitor
   import fault_monitor_pkg::*;
#(
   parameter int unsigned          NumRegions        = 2,
   parameter int unsigned          AddrWidth         = 32,
   parameter int unsigned          FsmWidth          = 3,
   parameter logic [FsmWidth-1:0]  ForbiddenFsmState = FsmWidth'(3'b001),
   parameter int unsigned          CntWidth          = 4,
   parameter int unsigned          Threshold         = 1,
   parameter int unsigned          DecayPeriod       = 16,
   localparam int unsigned         NumInv            = NumRegions + 2
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [1:0]                           priv_lvl_i,
   input  logic                                 trap_taken_i,
   input  logic [FsmWidth-1:0]                  ctrl_fsm_cs_i,
   input  logic                                 data_req_i,
   input  logic [AddrWidth-1:0]                 data_addr_i,
   input  logic [NumRegions-1:0]                region_en_i,
   input  logic [NumRegions-1:0][AddrWidth-1:0] region_base_i,
   input  logic [NumRegions-1:0][AddrWidth-1:0] region_limit_i,
   input  logic                                 alarm_clear_i,
   output logic                                 alarm_o,
   output logic [NumInv-1:0]                    alarm_cause_o,
   output logic [CntWidth-1:0]                  viol_count_o
);

   priv_lvl_e           priv_cur;
   priv_lvl_e           prev_priv_q;
   logic                trap_q;
   logic                user_mode;
   logic [NumInv-1:0]   inv;
   logic                viol;
   logic [NumInv-1:0]   cause_q, cause_d;
   logic                alarm_q, alarm_d;
   logic                alarm_set;
   logic [CntWidth-1:0] count;
   logic [CntWidth-1:0] inc_val;

   assign priv_cur  = priv_lvl_e'(priv_lvl_i);
   assign user_mode = (priv_cur == PRIV_U);

   assign inv[INV_FSM]  = user_mode && (ctrl_fsm_cs_i == ForbiddenFsmState);
   assign inv[INV_PRIV] = (prev_priv_q == PRIV_U) && (priv_cur == PRIV_M) && !trap_q;

   // An inverted range (base > limit) fails one of the two bounds and never matches.
   for (genvar r = 0; r < NumRegions; r++) begin : g_region
      assign inv[INV_REGION_BASE + r] = user_mode && region_en_i[r] && data_req_i &&
                                        (data_addr_i >= region_base_i[r]) &&
                                        (data_addr_i <= region_limit_i[r]);
   end

   assign viol = |inv;

   fault_leaky_counter #(
      .CntWidth    (CntWidth),
      .DecayPeriod (DecayPeriod)
   ) u_counter (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (alarm_clear_i),
      .inc_i   (viol),
      .count_o (count)
   );

   // While the alarm is low the count stays below Threshold, so only an
   // increment can cross it; the post-increment value is enough.
   always_comb begin
      inc_val = '0;
      if (alarm_clear_i) begin
         inc_val = CntWidth'(1);
      end else if (&count) begin
         inc_val = count;
      end else begin
         inc_val = count + CntWidth'(1);
      end
      alarm_set = viol && (inc_val >= CntWidth'(Threshold));
      alarm_d   = (alarm_clear_i ? 1'b0 : alarm_q) | alarm_set;
      cause_d   = (alarm_clear_i ? '0 : cause_q) | inv;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_priv_q <= PRIV_M;
         trap_q      <= 1'b0;
         cause_q     <= '0;
         alarm_q     <= 1'b0;
      end else begin
         prev_priv_q <= priv_cur;
         trap_q      <= trap_taken_i;
         cause_q     <= cause_d;
         alarm_q     <= alarm_d;
      end
   end

   assign alarm_o       = alarm_q;
   assign alarm_cause_o = cause_q;
   assign viol_count_o  = count;

endmodule

// File: tb/tb_fault_alarm_monitor.sv
// Bench for fault_alarm_monitor: directed scenarios plus randomized traffic
// against a behavioural model, on a default and a Threshold=3/DecayPeriod=4 instance.
module tb_fault_alarm_monitor;
   import fault_monitor_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, trap, req, clr;
   logic [1:0]       priv;
   logic [2:0]       fsm;
   logic [31:0]      addr;
   logic [1:0]       en;
   logic [1:0][31:0] base, limit;
   logic             a0, a1;
   logic [3:0]       c0, c1, n0, n1;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model state, one counter/alarm per instance, shared cause.
   int       m_count[2];
   int       m_timer[2];
   bit       m_alarm[2];
   bit [3:0] m_cause;
   bit [1:0] m_prev;
   bit       m_trap;
   int       thr[2] = '{1, 3};
   int       per[2] = '{16, 4};

   fault_alarm_monitor dut0 (
      .clk_i(clk), .rst_i(rst), .priv_lvl_i(priv), .trap_taken_i(trap),
      .ctrl_fsm_cs_i(fsm), .data_req_i(req), .data_addr_i(addr),
      .region_en_i(en), .region_base_i(base), .region_limit_i(limit),
      .alarm_clear_i(clr), .alarm_o(a0), .alarm_cause_o(c0), .viol_count_o(n0)
   );

   fault_alarm_monitor #(.Threshold(3), .DecayPeriod(4)) dut1 (
      .clk_i(clk), .rst_i(rst), .priv_lvl_i(priv), .trap_taken_i(trap),
      .ctrl_fsm_cs_i(fsm), .data_req_i(req), .data_addr_i(addr),
      .region_en_i(en), .region_base_i(base), .region_limit_i(limit),
      .alarm_clear_i(clr), .alarm_o(a1), .alarm_cause_o(c1), .viol_count_o(n1)
   );

   task automatic model_step();
      bit [3:0] v;
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_count[i] = 0; m_timer[i] = 0; m_alarm[i] = 0;
         end
         m_cause = '0; m_prev = 2'b11; m_trap = 0;
         return;
      end
      v    = '0;
      v[0] = (priv == 2'b00) && (fsm == 3'b001);
      v[1] = (m_prev == 2'b00) && (priv == 2'b11) && !m_trap;
      for (int r = 0; r < 2; r++)
         v[2+r] = (priv == 2'b00) && en[r] && req &&
                  (addr >= base[r]) && (addr <= limit[r]);
      if (clr) m_cause = '0;
      m_cause = m_cause | v;
      for (int i = 0; i < 2; i++) begin
         if (clr) begin
            m_count[i] = 0; m_timer[i] = 0; m_alarm[i] = 0;
         end
         if (v != 0) begin
            m_count[i] = (m_count[i] < 15) ? m_count[i] + 1 : 15;
            m_timer[i] = 0;
         end else if (!clr && per[i] > 0) begin
            m_timer[i]++;
            if (m_timer[i] == per[i]) begin
               m_timer[i] = 0;
               if (m_count[i] > 0) m_count[i]--;
            end
         end
         if (m_count[i] >= thr[i]) m_alarm[i] = 1;
      end
      m_prev = priv;
      m_trap = trap;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 0; clr = 0; priv = PRIV_S; trap = 0; fsm = 3'd0; req = 0; addr = '0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      tick();
      tick();
      n_checks++;
      if ({a0, c0, n0, a1, c1, n1} !== 18'b0) begin
         n_errors++;
         $display("FAIL reset_state: got %b want 0", {a0, c0, n0, a1, c1, n1});
      end
      idle();
   endtask

   task automatic test_fsm_invariant();
      idle(); priv = PRIV_U; fsm = 3'b001;
      tick();
      n_checks++;
      if ({a0, c0, n0} !== {1'b1, 4'b0001, 4'd1}) begin
         n_errors++;
         $display("FAIL fsm_viol_dut0: got a=%b c=%b n=%0d want a=1 c=0001 n=1", a0, c0, n0);
      end
      n_checks++;
      if ({a1, n1} !== {1'b0, 4'd1}) begin
         n_errors++;
         $display("FAIL fsm_viol_dut1: got a=%b n=%0d want a=0 n=1", a1, n1);
      end
      idle(); clr = 1;
      tick();
      n_checks++;
      if ({a0, c0, n0, a1, c1, n1} !== 18'b0) begin
         n_errors++;
         $display("FAIL clear_alone: got %b want 0", {a0, c0, n0, a1, c1, n1});
      end
      idle();
   endtask

   task automatic test_region();
      idle(); priv = PRIV_U; req = 1; addr = 32'h10FF;
      tick();
      n_checks++;
      if (c0 !== 4'b1000) begin
         n_errors++;
         $display("FAIL region_limit_hit: got c=%b want 1000", c0);
      end
      idle(); clr = 1; tick();
      idle(); priv = PRIV_U; req = 1; addr = 32'h1100; tick();
      addr = 32'h0FFF; tick();
      n_checks++;
      if ({c0, n0} !== 8'b0) begin
         n_errors++;
         $display("FAIL region_outside: got c=%b n=%0d want 0 0", c0, n0);
      end
      idle(); tick();
      priv = PRIV_M; req = 1; addr = 32'h10FF; tick();
      n_checks++;
      if (c0 !== 4'b0000) begin
         n_errors++;
         $display("FAIL region_mmode: got c=%b want 0000", c0);
      end
      idle(); tick();
      base[0] = 32'h3000; limit[0] = 32'h2FFF; en[1] = 0;
      priv = PRIV_U; req = 1; addr = 32'h3000; tick();
      addr = 32'h1080; tick();
      n_checks++;
      if (c0 !== 4'b0000) begin
         n_errors++;
         $display("FAIL region_inverted_or_disabled: got c=%b want 0000", c0);
      end
      base[0] = 32'h2000; limit[0] = 32'h20FF; en = 2'b11;
      addr = 32'h1000; tick();
      n_checks++;
      if (c0 !== 4'b1000) begin
         n_errors++;
         $display("FAIL region_base_hit: got c=%b want 1000", c0);
      end
      idle(); tick();
   endtask

   task automatic test_priv_escalation();
      idle(); clr = 1; tick();
      idle(); priv = PRIV_U; tick();
      priv = PRIV_M; tick();
      n_checks++;
      if ({a0, c0} !== {1'b1, 4'b0010}) begin
         n_errors++;
         $display("FAIL escalation_no_trap: got a=%b c=%b want a=1 c=0010", a0, c0);
      end
      idle(); clr = 1; tick();
      idle(); priv = PRIV_U; trap = 1; tick();
      priv = PRIV_M; trap = 0; tick();
      n_checks++;
      if (c0 !== 4'b0000) begin
         n_errors++;
         $display("FAIL escalation_with_trap: got c=%b want 0000", c0);
      end
      idle(); tick();
      priv = PRIV_U; trap = 1; tick();
      trap = 0; tick();
      priv = PRIV_M; tick();
      n_checks++;
      if (c0 !== 4'b0010) begin
         n_errors++;
         $display("FAIL escalation_stale_trap: got c=%b want 0010", c0);
      end
      idle(); tick();
   endtask

   task automatic test_decay();
      idle(); clr = 1; tick();
      idle(); priv = PRIV_U; fsm = 3'b001; tick();
      idle(); tick();
      priv = PRIV_U; fsm = 3'b001; tick();
      idle();
      n_checks++;
      if ({a1, n1} !== {1'b0, 4'd2}) begin
         n_errors++;
         $display("FAIL decay_two_viol: got a=%b n=%0d want a=0 n=2", a1, n1);
      end
      for (int unsigned i = 0; i < 3; i++) tick();
      n_checks++;
      if (n1 !== 4'd2) begin
         n_errors++;
         $display("FAIL decay_3_quiet: got n=%0d want 2", n1);
      end
      tick();
      n_checks++;
      if ({a1, n1} !== {1'b0, 4'd1}) begin
         n_errors++;
         $display("FAIL decay_4_quiet: got a=%b n=%0d want a=0 n=1", a1, n1);
      end
      priv = PRIV_U; fsm = 3'b001; tick();
      n_checks++;
      if ({a1, n1} !== {1'b0, 4'd2}) begin
         n_errors++;
         $display("FAIL decay_below_thr: got a=%b n=%0d want a=0 n=2", a1, n1);
      end
      tick();
      n_checks++;
      if ({a1, n1} !== {1'b1, 4'd3}) begin
         n_errors++;
         $display("FAIL decay_reach_thr: got a=%b n=%0d want a=1 n=3", a1, n1);
      end
      idle();
      for (int unsigned i = 0; i < 4; i++) tick();
      n_checks++;
      if ({a1, n1} !== {1'b1, 4'd2}) begin
         n_errors++;
         $display("FAIL alarm_sticky_decay: got a=%b n=%0d want a=1 n=2", a1, n1);
      end
   endtask

   task automatic test_clear_concurrent();
      idle(); clr = 1; priv = PRIV_U; req = 1; addr = 32'h2000;
      tick();
      n_checks++;
      if ({a0, c0, n0} !== {1'b1, 4'b0100, 4'd1}) begin
         n_errors++;
         $display("FAIL clear_with_viol_dut0: got a=%b c=%b n=%0d want a=1 c=0100 n=1", a0, c0, n0);
      end
      n_checks++;
      if ({a1, c1, n1} !== {1'b0, 4'b0100, 4'd1}) begin
         n_errors++;
         $display("FAIL clear_with_viol_dut1: got a=%b c=%b n=%0d want a=0 c=0100 n=1", a1, c1, n1);
      end
      idle(); tick();
   endtask

   task automatic test_saturate_reset();
      idle(); priv = PRIV_U; fsm = 3'b001;
      for (int unsigned i = 0; i < 20; i++) tick();
      n_checks++;
      if ({a0, n0, a1, n1} !== {1'b1, 4'd15, 1'b1, 4'd15}) begin
         n_errors++;
         $display("FAIL saturate: got a0=%b n0=%0d a1=%b n1=%0d want 1 15 1 15", a0, n0, a1, n1);
      end
      rst = 1; clr = 1; req = 1; addr = 32'h2000;
      tick();
      n_checks++;
      if ({a0, c0, n0, a1, c1, n1} !== 18'b0) begin
         n_errors++;
         $display("FAIL reset_mid_op: got %b want 0", {a0, c0, n0, a1, c1, n1});
      end
      idle(); priv = PRIV_M; tick();
      n_checks++;
      if ({a0, c0, n0} !== 9'b0) begin
         n_errors++;
         $display("FAIL post_reset_mmode: got a=%b c=%b n=%0d want 0", a0, c0, n0);
      end
      idle(); tick();
   endtask

   task automatic test_random();
      logic [31:0] pick[8] = '{32'h0FFF, 32'h1000, 32'h1080, 32'h10FF,
                               32'h1100, 32'h2000, 32'h20FF, 32'h2100};
      for (int unsigned i = 0; i < 400; i++) begin
         rst  = ($urandom_range(0, 63) == 0);
         clr  = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 2))
            0:       priv = PRIV_U;
            1:       priv = PRIV_S;
            default: priv = PRIV_M;
         endcase
         trap = ($urandom_range(0, 3) == 0);
         fsm  = ($urandom_range(0, 5) == 0) ? 3'b001 : 3'($urandom_range(0, 7));
         req  = $urandom_range(0, 1) == 1;
         addr = ($urandom_range(0, 7) == 0) ? 32'($urandom) : pick[$urandom_range(0, 7)];
         en   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
         tick();
         n_checks++;
         if ({a0, c0, n0} !== {m_alarm[0], m_cause, 4'(m_count[0])}) begin
            n_errors++;
            $display("FAIL rand_dut0 cycle %0d: got a=%b c=%b n=%0d want a=%b c=%b n=%0d",
                     i, a0, c0, n0, m_alarm[0], m_cause, m_count[0]);
         end
         n_checks++;
         if ({a1, c1, n1} !== {m_alarm[1], m_cause, 4'(m_count[1])}) begin
            n_errors++;
            $display("FAIL rand_dut1 cycle %0d: got a=%b c=%b n=%0d want a=%b c=%b n=%0d",
                     i, a1, c1, n1, m_alarm[1], m_cause, m_count[1]);
         end
      end
      idle();
   endtask

   initial begin
      en       = 2'b11;
      base[0]  = 32'h2000; limit[0] = 32'h20FF;
      base[1]  = 32'h1000; limit[1] = 32'h10FF;
      idle();
      rst = 1;
      #2;
      test_reset();
      test_fsm_invariant();
      test_region();
      test_priv_escalation();
      test_decay();
      test_clear_concurrent();
      test_saturate_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fault_alarm_monitor.md
# fault_alarm_monitor

Parametrised, clocked fault-attack monitor for the Ibex core. It evaluates a vector of security invariants every cycle: forbidden controller FSM state in user mode, user-mode data accesses to N protected address regions, and illegal user-to-machine privilege escalation without a trap. Violations feed a leaky saturating counter and a sticky cause register, and raise a registered, sticky alarm once a configurable threshold is reached. It sits beside the core and taps controller, CSR and LSU signals.

## Interface
- `NumRegions`, 2: number of protected address ranges (≥1).
- `AddrWidth`, 32: data address width.
- `FsmWidth`, 3: width of `ctrl_fsm_cs_i`.
- `ForbiddenFsmState`, 3'b001: FSM encoding illegal in user mode.
- `CntWidth`, 4: violation counter width.
- `Threshold`, 1: counter value at which the alarm asserts (1..2^CntWidth-1).
- `DecayPeriod`, 16: violation-free cycles per counter decrement; 0 disables decay.
- Derived `NumInv` = NumRegions + 2.

- `clk_i` in 1: single clock, all state on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `priv_lvl_i` in 2: current privilege (cs_registers priv_lvl_q).
- `trap_taken_i` in 1: exception/interrupt taken this cycle.
- `ctrl_fsm_cs_i` in FsmWidth: controller FSM state.
- `data_req_i` in 1: LSU data request.
- `data_addr_i` in AddrWidth: LSU data address.
- `region_en_i` in NumRegions: per-region enable.
- `region_base_i` in NumRegions×AddrWidth: inclusive lower bound.
- `region_limit_i` in NumRegions×AddrWidth: inclusive upper bound.
- `alarm_clear_i` in 1: single-cycle clear request.
- `alarm_o` out 1: sticky alarm.
- `alarm_cause_o` out NumInv: sticky per-invariant violation flags.
- `viol_count_o` out CntWidth: current leaky counter value.

## Operation
- Invariant index: 0 = FSM, 1 = privilege escalation, 2+r = region r.
- Inv 0 violated: priv_lvl_i == PRIV_U and ctrl_fsm_cs_i == ForbiddenFsmState.
- Inv 2+r violated: priv_lvl_i == PRIV_U, region_en_i[r], data_req_i, base ≤ addr ≤ limit (unsigned). base > limit matches nothing.
- Inv 1 violated (any privilege): prev_priv_q == PRIV_U, priv_lvl_i == PRIV_M, trap_q == 0; prev_priv_q/trap_q are last cycle's priv_lvl_i/trap_taken_i.
- `viol` = OR of violation vector (combinational, internal only).
- Counter: viol → saturating +1; else decay timer counts; at DecayPeriod-1 timer wraps to 0 and counter decrements (floor 0). Any viol resets timer to 0.
- Cause: cause_q |= violation vector every cycle.
- Alarm: set when next counter value ≥ Threshold; stays set regardless of later decay.
- Clear: alarm_clear_i zeroes alarm, cause, counter, timer. Violation in same cycle wins: result is as if applied to cleared state (counter 1, cause = that vector, alarm = 1 ≥ Threshold).

## Timing
- Reset values: alarm_o 0, alarm_cause_o 0, viol_count_o 0, timer 0, prev_priv_q PRIV_M, trap_q 0.
- Violation in cycle t → cause/counter updated and alarm_o visible in cycle t+1 (1-cycle latency).
- Escalation detected in the cycle priv reads PRIV_M; trap legitimises escalation only if asserted exactly one cycle earlier.
- Reset mid-operation overrides clear and violations; the reset cycle records nothing.
- Counter saturates at 2^CntWidth-1; no wrap.

## Structure
- Package `fault_monitor_pkg`: `priv_lvl_e` (PRIV_U=2'b00, PRIV_S=2'b01, PRIV_M=2'b11), index constants INV_FSM=0, INV_PRIV=1, INV_REGION_BASE=2.
- Sub-module `fault_leaky_counter` (params CntWidth, DecayPeriod; ports clk_i, rst_i, clr_i, inc_i, count_o): saturating counter plus decay timer.
- Top: invariant comparators (generate loop over regions), prev-priv/trap registers, cause/alarm registers.

## Test plan
- Priv U, ctrl_fsm_cs_i=3'b001 one cycle → next cycle alarm_o=1, alarm_cause_o=4'b0001, viol_count_o=1.
- Region 1 = 0x1000..0x10FF, U-mode req to 0x10FF → cause bit 3; req to 0x1100 or in M-mode → no violation.
- priv U→M without trap → cause bit 1 set; U, trap_taken_i, then M → no violation.
- Threshold=3, DecayPeriod=4: violations at cycles 0 and 2 → count 2, alarm 0; 4 quiet cycles → count 1; two more violations → alarm 1.
- Alarm set, alarm_clear_i alone → next cycle all outputs 0; clear with concurrent region-0 violation → count 1, cause 4'b0100, alarm 1.
- Assert rst_i while alarm=1 and count saturated (15) → all outputs 0 next cycle; priv=M after reset raises no escalation.
